// File: rtl/dither_scheduler.sv
// Floyd-Steinberg dither sequencer: walks the image in raster order over a
// single-port SRAM, thresholds each pixel and spreads its error to neighbours.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; memory port quiet
// RD_CUR   | present current pixel address for read
// WAIT_CUR | read data valid; threshold it and latch the signed error
// WR_CUR   | write the thresholded value back to the current pixel
// RD_N     | present the selected neighbour address for read
// WAIT_N   | read data valid; compute the saturated diffused value
// WR_N     | write the diffused value to the neighbour
// ADVANCE  | step to the next pixel in raster order
// DONE     | one-cycle completion pulse, then back to IDLE
module dither_scheduler #(
    parameter int IMAGEX           = 16,
    parameter int IMAGEY           = 16,
    parameter int RGB_SIZE         = 8,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX*IMAGEY)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [IMAGE_ADDR_WIDTH-1:0]   mem_addr,
    output logic                          mem_we,
    output logic [RGB_SIZE-1:0]           mem_wdata,
    input  logic [RGB_SIZE-1:0]           mem_rdata,
    output logic [$clog2(IMAGEX)-1:0]     cur_x,
    output logic [$clog2(IMAGEY)-1:0]     cur_y
);

    localparam int XW = $clog2(IMAGEX);
    localparam int YW = $clog2(IMAGEY);
    localparam int AW = IMAGE_ADDR_WIDTH;
    localparam int EW = RGB_SIZE + 1;
    localparam int PW = RGB_SIZE + 5;

    localparam logic [XW-1:0]        X_LAST  = XW'(IMAGEX - 1);
    localparam logic [YW-1:0]        Y_LAST  = YW'(IMAGEY - 1);
    localparam logic [RGB_SIZE-1:0]  PIX_MAX = {RGB_SIZE{1'b1}};
    localparam logic signed [PW-1:0] SAT_HI  = PW'((2**RGB_SIZE) - 1);

    typedef enum logic [3:0] {
        IDLE, RD_CUR, WAIT_CUR, WR_CUR, RD_N, WAIT_N, WR_N, ADVANCE, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic [1:0]               nb_q, nb_d;
    logic                     hi_q, hi_d;
    logic signed [EW-1:0]     err_q, err_d;
    logic [RGB_SIZE-1:0]      nval_q, nval_d;

    logic [3:0]               nb_ok;
    logic [2:0]               first_nb, next_nb;
    logic [AW-1:0]            cur_addr, nb_addr, nb_off;
    logic signed [PW-1:0]     weight, err_ext, prod, sum;
    logic [RGB_SIZE-1:0]      new_pix;

    // Lowest-indexed in-image neighbour at or after 'from'; bit 2 = found.
    function automatic logic [2:0] pick(input logic [3:0] ok, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (3'(i) >= from && ok[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            nb_q    <= '0;
            hi_q    <= 1'b0;
            err_q   <= '0;
            nval_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            nb_q    <= nb_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            nval_q  <= nval_d;
        end
    end

    // Neighbour order E, SW, S, SE; anything off the image is never visited.
    always_comb begin
        nb_ok[0] = (x_q != X_LAST);
        nb_ok[1] = (x_q != '0) && (y_q != Y_LAST);
        nb_ok[2] = (y_q != Y_LAST);
        nb_ok[3] = (x_q != X_LAST) && (y_q != Y_LAST);
        first_nb = pick(nb_ok, 3'd0);
        next_nb  = pick(nb_ok, {1'b0, nb_q} + 3'd1);
    end

    always_comb begin
        nb_off = AW'(1);
        weight = PW'(7);
        case (nb_q)
            2'd0: begin nb_off = AW'(1);          weight = PW'(7); end
            2'd1: begin nb_off = AW'(IMAGEX - 1); weight = PW'(3); end
            2'd2: begin nb_off = AW'(IMAGEX);     weight = PW'(5); end
            default: begin nb_off = AW'(IMAGEX + 1); weight = PW'(1); end
        endcase
        cur_addr = AW'(y_q) * AW'(IMAGEX) + AW'(x_q);
        nb_addr  = cur_addr + nb_off;
    end

    // Error diffusion: v + floor(err*w / 16), clamped to the pixel range.
    always_comb begin
        err_ext = {{(PW-EW){err_q[EW-1]}}, err_q};
        prod    = err_ext * weight;
        sum     = $signed({{(PW-RGB_SIZE){1'b0}}, mem_rdata}) + (prod >>> 4);
        new_pix = mem_rdata[RGB_SIZE-1] ? PIX_MAX : '0;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        nb_d      = nb_q;
        hi_d      = hi_q;
        err_d     = err_q;
        nval_d    = nval_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = RD_CUR;
                end
            end
            RD_CUR: begin
                busy     = 1'b1;
                mem_addr = cur_addr;
                state_d  = WAIT_CUR;
            end
            WAIT_CUR: begin
                busy     = 1'b1;
                mem_addr = cur_addr;
                hi_d     = mem_rdata[RGB_SIZE-1];
                err_d    = $signed({1'b0, mem_rdata}) - $signed({1'b0, new_pix});
                state_d  = WR_CUR;
            end
            WR_CUR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = hi_q ? PIX_MAX : '0;
                if (first_nb[2]) begin
                    nb_d    = first_nb[1:0];
                    state_d = RD_N;
                end else begin
                    state_d = ADVANCE;
                end
            end
            RD_N: begin
                busy     = 1'b1;
                mem_addr = nb_addr;
                state_d  = WAIT_N;
            end
            WAIT_N: begin
                busy     = 1'b1;
                mem_addr = nb_addr;
                if (sum[PW-1])
                    nval_d = '0;
                else if (sum > SAT_HI)
                    nval_d = PIX_MAX;
                else
                    nval_d = sum[RGB_SIZE-1:0];
                state_d  = WR_N;
            end
            WR_N: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = nb_addr;
                mem_wdata = nval_q;
                if (next_nb[2]) begin
                    nb_d    = next_nb[1:0];
                    state_d = RD_N;
                end else begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                busy = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = DONE;
                    end else begin
                        y_d     = y_q + YW'(1);
                        state_d = RD_CUR;
                    end
                end else begin
                    x_d     = x_q + XW'(1);
                    state_d = RD_CUR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_x = x_q;
    assign cur_y = y_q;

endmodule

// File: doc/dither_scheduler.md
DITHER_SCHEDULER -- requirements
Module: dither_scheduler

Interface
REQ-001 SHALL have parameter IMAGEX, default 16, meaning image width in pixels.
REQ-002 SHALL have parameter IMAGEY, default 16, meaning image height in pixels.
REQ-003 SHALL have parameter RGB_SIZE, default 8, meaning pixel width in bits.
REQ-004 SHALL have parameter IMAGE_ADDR_WIDTH, default $clog2(IMAGEX*IMAGEY), meaning SRAM address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1, one-cycle request to dither the whole image.
REQ-008 SHALL have port busy, output, 1, high while a pass is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a pass completes.
REQ-010 SHALL have port mem_addr, output, IMAGE_ADDR_WIDTH, SRAM address, y*IMAGEX+x.
REQ-011 SHALL have port mem_we, output, 1, SRAM write enable.
REQ-012 SHALL have port mem_wdata, output, RGB_SIZE, SRAM write data.
REQ-013 SHALL have port mem_rdata, input, RGB_SIZE, SRAM read data, valid one cycle after the address is presented with mem_we=0.
REQ-014 SHALL have ports cur_x and cur_y, output, IMAGEX/IMAGEY log2 widths, coordinate of the pixel being processed.

Function
REQ-015 SHALL implement states IDLE, RD_CUR, WAIT_CUR, WR_CUR, RD_N, WAIT_N, WR_N, ADVANCE, DONE.
REQ-016 SHALL leave IDLE for RD_CUR only when start=1; start SHALL be ignored in all other states.
REQ-017 SHALL traverse pixels in raster order: x from 0 to IMAGEX-1 within each row, y from 0 to IMAGEY-1.
REQ-018 SHALL sample old = mem_rdata in WAIT_CUR.
REQ-019 SHALL compute new = 255 if old >= 128, else 0.
REQ-020 SHALL compute signed error err = old - new, 9 bits.
REQ-021 SHALL write new to the current address in WR_CUR.
REQ-022 SHALL visit neighbours in fixed order E(x+1,y) weight 7, SW(x-1,y+1) weight 3, S(x,y+1) weight 5, SE(x+1,y+1) weight 1.
REQ-023 SHALL skip neighbours outside the image in zero cycles: E and SE when x=IMAGEX-1; SW when x=0; SW, S and SE when y=IMAGEY-1.
REQ-024 SHALL, per visited neighbour, issue a read in RD_N, sample in WAIT_N, and write in WR_N the value v + ((err*w) arithmetic-shift-right 4), using floor rounding and at least 13-bit signed intermediates.
REQ-025 SHALL saturate the written neighbour value: results below 0 write 0, results above 255 write 255.
REQ-026 SHALL step the coordinate in ADVANCE and go to DONE after the last pixel (IMAGEX-1, IMAGEY-1); no address wrap beyond the image.
REQ-027 SHALL take 4+3k cycles per pixel, where k is the number of visited neighbours.
REQ-028 SHALL hold busy=1 in every state except IDLE and DONE.
REQ-029 SHALL assert done=1 only in DONE, which lasts one cycle and then returns to IDLE.
REQ-030 SHALL assert mem_we only in WR_CUR and WR_N.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, enter IDLE with busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, cur_x=0, cur_y=0, err=0.
REQ-032 SHALL let rst override start and any in-progress state; a partial pass is abandoned, and the next start restarts at (0,0).

Verification (IMAGEX=IMAGEY=4)
REQ-033 SHALL cover: all pixels 0xFF, start -> busy high exactly 190 cycles, then one done pulse, and memory unchanged (all 0xFF).
REQ-034 SHALL cover: pixel0=0x64, all others 0x10 -> first writes are addr0=0x00, addr1=0x3B, addr4=0x2F, addr5=0x16 (SW skipped).
REQ-035 SHALL cover: pixel0=0x7F, pixel1=0xF0 -> addr0 written 0x00, then addr1 written 0xFF (positive saturation).
REQ-036 SHALL cover: pixel0=0x81, others 0x20 -> addr0=0xFF, err=-126, addr1=0x00 (32-56 clamps), addr4=0x00.
REQ-037 SHALL cover: start pulsed while busy -> no effect, and cycle count stays 190.
REQ-038 SHALL cover: rst during WAIT_N of pixel 5 -> the next cycle shows mem_we=0, busy=0, cur_x=cur_y=0, and a new start reprocesses from addr0.
